bus_arbiter: RTL

- Round-robin arbiter and sequencer for the shared op/adr/data bus (op 2b, adr 16b, data 32b) between the bus masters and the memory slave.
- Accepts up to N_MASTERS transaction requests and grants one at a time.
- Drives a single bus cycle per transaction, waits READ_LAT cycles for read data, and returns completion to the winning master.
- Sits between the master-side script drivers and the op_reg/adr_reg/data_write bus registers.

---
 rtl/bus_pkg.sv | 10 +
 rtl/rr_pick.sv | 21 ++
 rtl/bus_arbiter.sv | 96 +++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// bus_pkg: shared bus op encodings, widths and arbiter state type.
package bus_pkg;
    localparam logic [1:0] OP_IDLE  = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;
    localparam int ADR_W  = 16;
    localparam int DATA_W = 32;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin winner select, first eligible index at or after ptr_i.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  elig_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  win_o,
    output logic          any_o
);
    // scan farthest-first so the closest eligible index to ptr_i overwrites last
    always_comb begin
        win_o = '0;
        for (int k = N - 1; k >= 0; k--)
            if (elig_i[(int'(ptr_i) + k) % N]) begin
                win_o = '0;
                win_o[(int'(ptr_i) + k) % N] = 1'b1;
            end
    end
    assign any_o = |elig_i;
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter that sequences one bus transaction per grant.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int N_MASTERS = 4,
    parameter int READ_LAT  = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [N_MASTERS-1:0]          req,
    input  logic [2*N_MASTERS-1:0]        req_op,
    input  logic [ADR_W*N_MASTERS-1:0]    req_adr,
    input  logic [DATA_W*N_MASTERS-1:0]   req_wdata,
    output logic [N_MASTERS-1:0]          gnt,
    output logic [N_MASTERS-1:0]          done,
    output logic [DATA_W-1:0]             rdata,
    output logic [1:0]                    bus_op,
    output logic [ADR_W-1:0]              bus_adr,
    output logic [DATA_W-1:0]             bus_wdata,
    input  logic [DATA_W-1:0]             bus_rdata
);
    localparam int IW = $clog2(N_MASTERS);

    state_t              state_q, state_d;
    logic [IW-1:0]       w_q, ptr_q, win_idx;
    logic [1:0]          op_q;
    logic [ADR_W-1:0]    adr_q;
    logic [DATA_W-1:0]   wdata_q, rdata_q;
    logic [3:0]          cnt_q;
    logic [N_MASTERS-1:0] elig, win;
    logic                any;

    for (genvar i = 0; i < N_MASTERS; i++) begin : g_elig
        assign elig[i] = req[i] & (req_op[2*i +: 2] == OP_READ || req_op[2*i +: 2] == OP_WRITE);
    end

    rr_pick #(.N(N_MASTERS)) u_pick (
        .elig_i(elig),
        .ptr_i (ptr_q),
        .win_o (win),
        .any_o (any)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_MASTERS; i++)
            if (win[i]) win_idx = IW'(i);
    end

    always_ff @(posedge clock)
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  state_d = any ? ISSUE : IDLE;
            ISSUE: state_d = (op_q == OP_WRITE) ? DONE : WAIT;
            WAIT:  state_d = (cnt_q == 4'd0) ? DONE : WAIT;
            DONE:  state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt    = (state_q != IDLE) ? N_MASTERS'(1) << w_q : '0;
        done   = (state_q == DONE) ? N_MASTERS'(1) << w_q : '0;
        bus_op = (state_q == ISSUE) ? op_q : OP_IDLE;
    end

    // request fields are captured once in IDLE; later req changes cannot disturb the transaction
    always_ff @(posedge clock)
        if (reset) begin
            w_q     <= '0;
            ptr_q   <= '0;
            op_q    <= OP_IDLE;
            adr_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            if (state_q == IDLE && any) begin
                w_q     <= win_idx;
                op_q    <= req_op[2*win_idx +: 2];
                adr_q   <= req_adr[ADR_W*win_idx +: ADR_W];
                wdata_q <= req_wdata[DATA_W*win_idx +: DATA_W];
            end
            if (state_q == ISSUE)     cnt_q <= 4'(READ_LAT - 1);
            else if (state_q == WAIT) cnt_q <= cnt_q - 4'd1;
            if (state_q == WAIT && cnt_q == 4'd0) rdata_q <= bus_rdata;
            if (state_q == DONE) ptr_q <= (w_q == IW'(N_MASTERS - 1)) ? '0 : w_q + IW'(1);
        end

    assign rdata     = rdata_q;
    assign bus_adr   = adr_q;
    assign bus_wdata = wdata_q;
endmodule
